hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the rs/rt forwarding units. It resolves the hazards forwarding cannot cover:
- load-use,
- HI/LO access while the multi-cycle multiply/divide unit is busy,
- taken-branch flush.

It drives the PC/IF_ID write enables and the IF_ID/ID_EX flush controls, and it owns the mult/div busy counter and its completion strobe.

---
 rtl/hazard_stall_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / HI-LO / branch hazard sequencer with mult/div busy counter
module hazard_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_ID_Instr,
    input  logic [31:0] ID_EX_Instr,
    input  logic        IF_ID_isR_s,
    input  logic        IF_ID_isR_t,
    input  logic        IF_ID_isHiLo,
    input  logic        ID_EX_isLoad,
    input  logic        ID_EX_isMD,
    input  logic        EX_branch_taken,
    output logic        PC_Write_en,
    output logic        IF_ID_Write_en,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        md_busy,
    output logic        md_done
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          md_done_q, md_done_d;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rt;
    logic       ex_is_div;
    logic       load_use;
    logic       hilo_haz;
    logic       stall;

    assign id_rs     = IF_ID_Instr[25:21];
    assign id_rt     = IF_ID_Instr[20:16];
    assign ex_rt     = ID_EX_Instr[20:16];
    // funct bit 1 separates div/divu (0x1a/0x1b) from mult/multu (0x18/0x19)
    assign ex_is_div = ID_EX_Instr[1];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{IF_ID_Instr[31:26], IF_ID_Instr[15:0],
                                 ID_EX_Instr[31:21], ID_EX_Instr[15:2], ID_EX_Instr[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            md_cnt_q  <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
        end
    end

    // An MD issue while already busy is ignored; the HI/LO stall keeps it from happening.
    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ID_EX_isMD) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = ex_is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == '0) begin
                    state_d   = IDLE;
                    md_done_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = '0;
            end
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);
    assign md_done = md_done_q;

    assign load_use = ID_EX_isLoad && (ex_rt != 5'd0) &&
                      ((IF_ID_isR_s && (id_rs == ex_rt)) ||
                       (IF_ID_isR_t && (id_rt == ex_rt)));

    assign hilo_haz = IF_ID_isHiLo && (md_busy || ID_EX_isMD);

    // A taken branch wins: the instruction that would stall is on the wrong path.
    assign stall = (load_use || hilo_haz) && !EX_branch_taken;

    assign PC_Write_en    = !stall;
    assign IF_ID_Write_en = !stall;
    assign IF_ID_Flush    = EX_branch_taken;
    assign ID_EX_Flush    = stall || EX_branch_taken;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - vector table and cycle sequences for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_ID_Instr, ID_EX_Instr;
    logic        IF_ID_isR_s, IF_ID_isR_t, IF_ID_isHiLo;
    logic        ID_EX_isLoad, ID_EX_isMD, EX_branch_taken;
    logic        PC_Write_en, IF_ID_Write_en, IF_ID_Flush, ID_EX_Flush;
    logic        md_busy, md_done;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_Instr(IF_ID_Instr), .ID_EX_Instr(ID_EX_Instr),
        .IF_ID_isR_s(IF_ID_isR_s), .IF_ID_isR_t(IF_ID_isR_t), .IF_ID_isHiLo(IF_ID_isHiLo),
        .ID_EX_isLoad(ID_EX_isLoad), .ID_EX_isMD(ID_EX_isMD), .EX_branch_taken(EX_branch_taken),
        .PC_Write_en(PC_Write_en), .IF_ID_Write_en(IF_ID_Write_en),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .md_busy(md_busy), .md_done(md_done)
    );

    // in  = {isR_s, isR_t, isHiLo, isLoad, isMD, branch}
    // exp = {PC_Write_en, IF_ID_Write_en, IF_ID_Flush, ID_EX_Flush, md_busy, md_done}
    typedef struct {
        logic [31:0] idi;
        logic [31:0] exi;
        logic [5:0]  in;
        logic [5:0]  ex;
        string       tag;
    } vec_t;

    localparam logic [5:0] RS = 6'b100000, RT = 6'b010000, HL = 6'b001000;
    localparam logic [5:0] LD = 6'b000100, MD = 6'b000010, BR = 6'b000001;
    localparam logic [5:0] RUN = 6'b110000, STALL = 6'b000100, BRF = 6'b111100;
    localparam logic [5:0] BUSY = 6'b000010, DONE = 6'b000001;

    vec_t sb_q[$];
    vec_t tbl[11];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [5:0] funct);
        return {6'd0, rs, rt, 10'd0, funct};
    endfunction

    function automatic vec_t mkv(input logic [31:0] idi, input logic [31:0] exi,
                                 input logic [5:0] in, input logic [5:0] ex, input string tag);
        vec_t v;
        v.idi = idi; v.exi = exi; v.in = in; v.ex = ex; v.tag = tag;
        return v;
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (pcwe,ifwe,iffl,exfl,busy,done)", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        IF_ID_Instr = v.idi;
        ID_EX_Instr = v.exi;
        {IF_ID_isR_s, IF_ID_isR_t, IF_ID_isHiLo, ID_EX_isLoad, ID_EX_isMD, EX_branch_taken} = v.in;
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        chk(e.tag, {PC_Write_en, IF_ID_Write_en, IF_ID_Flush, ID_EX_Flush, md_busy, md_done}, e.ex);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] lw8, mult_i, div_i, mfhi_i, nop_i;

    initial begin
        lw8    = ins(5'd2, 5'd8, 6'h00);
        mult_i = ins(5'd3, 5'd4, 6'h18);
        div_i  = ins(5'd3, 5'd4, 6'h1a);
        mfhi_i = ins(5'd0, 5'd0, 6'h10);
        nop_i  = 32'd0;

        tbl[0]  = mkv(nop_i, nop_i, 6'b0, RUN, "idle");
        tbl[1]  = mkv(ins(5'd8, 5'd1, 6'h20), lw8, RS | LD, STALL, "lu_rs");
        tbl[2]  = mkv(ins(5'd0, 5'd1, 6'h20), ins(5'd2, 5'd0, 6'h0), RS | LD, RUN, "lu_rt0");
        tbl[3]  = mkv(ins(5'd3, 5'd4, 6'h20), lw8, RS | RT | LD, RUN, "lu_nodep");
        tbl[4]  = mkv(ins(5'd3, 5'd8, 6'h20), lw8, RS | LD, RUN, "lu_rt_noread");
        tbl[5]  = mkv(ins(5'd3, 5'd8, 6'h20), lw8, RS | RT | LD, STALL, "lu_rt");
        tbl[6]  = mkv(ins(5'd8, 5'd1, 6'h20), lw8, RS, RUN, "match_noload");
        tbl[7]  = mkv(ins(5'd8, 5'd1, 6'h20), lw8, RS | LD | BR, BRF, "lu_branch");
        tbl[8]  = mkv(nop_i, nop_i, BR, BRF, "branch");
        tbl[9]  = mkv(mfhi_i, nop_i, HL, RUN, "hilo_idle");
        tbl[10] = mkv(ins(5'd8, 5'd8, 6'h20), lw8, RS | RT | LD, STALL, "lu_both");

        rst = 1'b1;
        IF_ID_Instr = '0; ID_EX_Instr = '0;
        {IF_ID_isR_s, IF_ID_isR_t, IF_ID_isHiLo, ID_EX_isLoad, ID_EX_isMD, EX_branch_taken} = '0;
        #12;
        chk("reset", {PC_Write_en, IF_ID_Write_en, IF_ID_Flush, ID_EX_Flush, md_busy, md_done}, RUN);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) apply(tbl[i]);

        // lw then dependent add: one stall cycle, bubble then clears the load in EX
        apply(mkv(ins(5'd8, 5'd1, 6'h20), lw8, RS | LD, STALL, "lu_seq0"));
        apply(mkv(ins(5'd8, 5'd1, 6'h20), nop_i, RS, RUN, "lu_seq1"));

        // mult in EX with mfhi held in ID
        apply(mkv(mfhi_i, mult_i, HL | MD, STALL, "mul_c0"));
        for (int c = 1; c <= 4; c++)
            apply(mkv(mfhi_i, lw8, (c == 2) ? (HL | LD) : HL, STALL | BUSY,
                      $sformatf("mul_c%0d", c)));
        apply(mkv(mfhi_i, nop_i, HL, RUN | DONE, "mul_c5"));
        apply(mkv(nop_i, mfhi_i, 6'b0, RUN, "mul_c6"));

        // div then a second div waiting in ID
        apply(mkv(div_i, div_i, HL | MD, STALL, "div_c0"));
        for (int c = 1; c <= 32; c++)
            apply(mkv(div_i, nop_i, HL, STALL | BUSY, $sformatf("div_c%0d", c)));
        apply(mkv(div_i, nop_i, HL, RUN | DONE, "div_c33"));
        apply(mkv(nop_i, div_i, MD, RUN, "div2_c34"));
        for (int c = 35; c <= 66; c++)
            apply(mkv(nop_i, nop_i, 6'b0, RUN | BUSY, $sformatf("div2_c%0d", c)));
        apply(mkv(nop_i, nop_i, 6'b0, RUN | DONE, "div2_c67"));
        apply(mkv(nop_i, nop_i, 6'b0, RUN, "div2_c68"));

        // taken branch during an in-flight mult
        apply(mkv(nop_i, mult_i, MD, RUN, "br_c0"));
        apply(mkv(ins(5'd8, 5'd1, 6'h20), lw8, RS | LD | BR, BRF | BUSY, "br_c1"));
        apply(mkv(mfhi_i, nop_i, HL | BR, BRF | BUSY, "br_c2"));
        apply(mkv(nop_i, nop_i, 6'b0, RUN | BUSY, "br_c3"));
        apply(mkv(nop_i, nop_i, 6'b0, RUN | BUSY, "br_c4"));
        apply(mkv(nop_i, nop_i, 6'b0, RUN | DONE, "br_c5"));

        // asynchronous reset in cycle 2 of a div
        apply(mkv(nop_i, div_i, MD, RUN, "rst_c0"));
        apply(mkv(nop_i, nop_i, 6'b0, RUN | BUSY, "rst_c1"));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {PC_Write_en, IF_ID_Write_en, IF_ID_Flush, ID_EX_Flush, md_busy, md_done}, RUN);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 40; c++)
            apply(mkv(nop_i, nop_i, 6'b0, RUN, $sformatf("rst_quiet%0d", c)));
        apply(mkv(nop_i, mult_i, MD, RUN, "post_mul_c0"));
        for (int c = 1; c <= 4; c++)
            apply(mkv(nop_i, nop_i, 6'b0, RUN | BUSY, $sformatf("post_mul_c%0d", c)));
        apply(mkv(nop_i, nop_i, 6'b0, RUN | DONE, "post_mul_c5"));
        apply(mkv(nop_i, nop_i, 6'b0, RUN, "post_mul_c6"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
